branch_predictor_gshare: RTL and testbench

- Parametrised fetch-stage branch predictor: gshare pattern history table (PHT) of saturating counters plus tagged branch target buffer (BTB).
- Predicts direction and target for the fetch PC in the same cycle.
- Maintains a speculative global history register (GHR); trains and recovers from execute-stage resolution.
- Successor of the single-table predictor feeding the 5-stage pipeline's nextPC mux; adds history, tags, counter width, recovery and performance counters.

---
 rtl/bp_pkg.sv | 33 +++
 rtl/sat_counter_array.sv | 45 ++++
 rtl/branch_predictor_gshare.sv | 110 +++++++++++
 tb/tb_branch_predictor_gshare.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Purpose: shared types, field offsets and counter arithmetic for the gshare predictor.
// Latency: n/a (package only).
// Backpressure: n/a.
package bp_pkg;

    // Default geometry; the BTB entry struct is sized from these.
    localparam int BP_XLEN     = 32;
    localparam int BP_TAG_BITS = 10;

    // Word-aligned instructions: index fields start above the byte offset.
    localparam int PC_IDX_LSB  = 2;

    typedef struct packed {
        logic                   valid;
        logic [BP_TAG_BITS-1:0] tag;
        logic [BP_XLEN-1:0]     target;
    } btb_entry_t;

    // Saturating up/down step for a counter of 'width' bits held in 32 bits.
    function automatic logic [31:0] counter_update(
        input logic [31:0] ctr,
        input logic        taken,
        input int unsigned width
    );
        logic [31:0] max_v;
        max_v = (32'd1 << width) - 32'd1;
        if (taken) begin
            return (ctr >= max_v) ? max_v : ctr + 32'd1;
        end
        return (ctr == 32'd0) ? 32'd0 : ctr - 32'd1;
    endfunction

endpackage

// File: rtl/sat_counter_array.sv
// Purpose: flop-based table of saturating counters (gshare PHT), one read and one write port.
// Latency: read is combinational; a write becomes visible on the cycle after it.
// Backpressure: none; a write is accepted every cycle it is presented.
module sat_counter_array
    import bp_pkg::*;
#(
    parameter int ENTRIES  = 256,
    parameter int CTR_BITS = 2,
    parameter int IDX_BITS = $clog2(ENTRIES)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [IDX_BITS-1:0] rd_idx,
    output logic                rd_taken,
    input  logic                wr_en,
    input  logic [IDX_BITS-1:0] wr_idx,
    input  logic                wr_taken
);

    // Weakly not-taken: just below the MSB threshold.
    localparam logic [CTR_BITS-1:0] RESET_VAL = CTR_BITS'((32'd1 << (CTR_BITS - 1)) - 32'd1);

    logic [CTR_BITS-1:0] ctr [ENTRIES];
    logic [31:0]         wr_next_wide;
    logic                unused_wide;

    assign rd_taken = ctr[rd_idx][CTR_BITS-1];

    always_comb begin
        wr_next_wide = counter_update(32'(ctr[wr_idx]), wr_taken, CTR_BITS);
    end

    assign unused_wide = ^wr_next_wide;

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctr[i] <= RESET_VAL;
            end
        end else if (wr_en) begin
            ctr[wr_idx] <= wr_next_wide[CTR_BITS-1:0];
        end
    end

endmodule

// File: rtl/branch_predictor_gshare.sv
// Purpose: fetch-stage gshare direction predictor plus tagged direct-mapped BTB and speculative GHR.
// Latency: prediction is combinational on fetch_pc; training and recovery land on the next cycle.
// Backpressure: none; lookups and updates are accepted every cycle.
module branch_predictor_gshare
    import bp_pkg::*;
#(
    parameter int XLEN        = BP_XLEN,
    parameter int BTB_ENTRIES = 64,
    parameter int PHT_ENTRIES = 256,
    parameter int GHR_BITS    = 8,
    parameter int CTR_BITS    = 2,
    parameter int TAG_BITS    = BP_TAG_BITS
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [XLEN-1:0]     fetch_pc,
    input  logic                fetch_valid,
    output logic                pred_taken,
    output logic [XLEN-1:0]     pred_target,
    output logic [GHR_BITS-1:0] pred_ghr,
    input  logic                upd_valid,
    input  logic [XLEN-1:0]     upd_pc,
    input  logic                upd_taken,
    input  logic [XLEN-1:0]     upd_target,
    input  logic [GHR_BITS-1:0] upd_ghr,
    input  logic                upd_mispredict,
    output logic [31:0]         perf_branches,
    output logic [31:0]         perf_mispredicts
);

    localparam int BTB_IDX_BITS = $clog2(BTB_ENTRIES);
    localparam int PHT_IDX_BITS = $clog2(PHT_ENTRIES);
    localparam int TAG_LSB      = PC_IDX_LSB + BTB_IDX_BITS;

    btb_entry_t btb [BTB_ENTRIES];
    logic [GHR_BITS-1:0] ghr;

    logic [BTB_IDX_BITS-1:0] fetch_btb_idx, upd_btb_idx;
    logic [TAG_BITS-1:0]     fetch_tag, upd_tag;
    logic [PHT_IDX_BITS-1:0] fetch_pht_idx, upd_pht_idx;
    btb_entry_t              fetch_entry;
    logic                    hit;
    logic                    pht_taken;
    logic                    unused_upd_pc;

    assign fetch_btb_idx = fetch_pc[PC_IDX_LSB +: BTB_IDX_BITS];
    assign fetch_tag     = fetch_pc[TAG_LSB +: TAG_BITS];
    assign fetch_pht_idx = fetch_pc[PC_IDX_LSB +: PHT_IDX_BITS] ^ PHT_IDX_BITS'(ghr);

    assign upd_btb_idx   = upd_pc[PC_IDX_LSB +: BTB_IDX_BITS];
    assign upd_tag       = upd_pc[TAG_LSB +: TAG_BITS];
    assign upd_pht_idx   = upd_pc[PC_IDX_LSB +: PHT_IDX_BITS] ^ PHT_IDX_BITS'(upd_ghr);

    // Byte offset and bits above the tag never participate in indexing.
    assign unused_upd_pc = ^upd_pc;

    sat_counter_array #(
        .ENTRIES  (PHT_ENTRIES),
        .CTR_BITS (CTR_BITS)
    ) u_pht (
        .clock    (clock),
        .reset    (reset),
        .rd_idx   (fetch_pht_idx),
        .rd_taken (pht_taken),
        .wr_en    (upd_valid),
        .wr_idx   (upd_pht_idx),
        .wr_taken (upd_taken)
    );

    assign fetch_entry = btb[fetch_btb_idx];
    assign hit         = fetch_entry.valid && (fetch_entry.tag == fetch_tag);
    assign pred_taken  = hit && pht_taken;
    assign pred_target = pred_taken ? fetch_entry.target : fetch_pc + XLEN'(4);
    assign pred_ghr    = ghr;

    // Only taken branches allocate; an aliasing entry is simply replaced.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                btb[i] <= '0;
            end
        end else if (upd_valid && upd_taken) begin
            btb[upd_btb_idx] <= '{valid: 1'b1, tag: upd_tag, target: upd_target};
        end
    end

    // Mispredict recovery rebuilds history from the branch's own snapshot and beats the fetch shift.
    always_ff @(posedge clock) begin
        if (reset) begin
            ghr <= '0;
        end else if (upd_valid && upd_mispredict) begin
            ghr <= {upd_ghr[GHR_BITS-2:0], upd_taken};
        end else if (fetch_valid && hit) begin
            ghr <= {ghr[GHR_BITS-2:0], pred_taken};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            perf_branches    <= '0;
            perf_mispredicts <= '0;
        end else if (upd_valid) begin
            perf_branches <= perf_branches + 32'd1;
            if (upd_mispredict) begin
                perf_mispredicts <= perf_mispredicts + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor_gshare.sv
// Directed bench for the gshare predictor: reset, training, saturation, recovery, aliasing, reset-vs-update.
module tb_branch_predictor_gshare;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] fetch_pc;
    logic        fetch_valid;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic [7:0]  pred_ghr;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic [7:0]  upd_ghr;
    logic        upd_mispredict;
    logic [31:0] perf_branches;
    logic [31:0] perf_mispredicts;

    int compared   = 0;
    int mismatched = 0;

    branch_predictor_gshare dut (
        .clock            (clock),
        .reset            (reset),
        .fetch_pc         (fetch_pc),
        .fetch_valid      (fetch_valid),
        .pred_taken       (pred_taken),
        .pred_target      (pred_target),
        .pred_ghr         (pred_ghr),
        .upd_valid        (upd_valid),
        .upd_pc           (upd_pc),
        .upd_taken        (upd_taken),
        .upd_target       (upd_target),
        .upd_ghr          (upd_ghr),
        .upd_mispredict   (upd_mispredict),
        .perf_branches    (perf_branches),
        .perf_mispredicts (perf_mispredicts)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                       input logic [7:0] gh, input logic mp);
        upd_valid      = 1'b1;
        upd_pc         = pc;
        upd_taken      = tk;
        upd_target     = tgt;
        upd_ghr        = gh;
        upd_mispredict = mp;
    endtask

    task automatic idle();
        upd_valid      = 1'b0;
        upd_mispredict = 1'b0;
        upd_taken      = 1'b0;
        fetch_valid    = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        fetch_pc = 32'h100;
        upd_pc = '0;
        upd_target = '0;
        upd_ghr = '0;
        idle();
        tick();
        tick();
        // Reset state
        check("rst_taken", 32'(pred_taken), 32'h0);
        check("rst_target", pred_target, 32'h104);
        check("rst_ghr", 32'(pred_ghr), 32'h0);
        check("rst_branches", perf_branches, 32'h0);
        check("rst_mispredicts", perf_mispredicts, 32'h0);
        reset = 1'b0;
        tick();

        // First training of 0x100: old value still seen during the write cycle
        upd(32'h100, 1'b1, 32'h80, 8'h00, 1'b0);
        #1;
        check("collide_taken", 32'(pred_taken), 32'h0);
        check("collide_target", pred_target, 32'h104);
        tick();
        idle();
        #1;
        check("train1_taken", 32'(pred_taken), 32'h1);
        check("train1_target", pred_target, 32'h80);
        check("train1_branches", perf_branches, 32'h1);

        // Saturation: 5 taken keep counter at 3
        for (int i = 0; i < 5; i++) begin
            upd(32'h100, 1'b1, 32'h80, 8'h00, 1'b0);
            tick();
        end
        idle();
        #1;
        check("sat_hi_taken", 32'(pred_taken), 32'h1);
        upd(32'h100, 1'b0, 32'h0, 8'h00, 1'b0);
        tick();
        idle();
        #1;
        check("sat_nt1_taken", 32'(pred_taken), 32'h1);
        check("sat_nt1_target", pred_target, 32'h80);
        upd(32'h100, 1'b0, 32'h0, 8'h00, 1'b0);
        tick();
        tick();
        idle();
        #1;
        check("sat_nt3_taken", 32'(pred_taken), 32'h0);
        check("sat_nt3_target", pred_target, 32'h104);
        // Extra not-taken must clamp at 0, so a single taken only reaches 1
        upd(32'h100, 1'b0, 32'h0, 8'h00, 1'b0);
        tick();
        upd(32'h100, 1'b1, 32'h80, 8'h00, 1'b0);
        tick();
        idle();
        #1;
        check("sat_lo_clamp", 32'(pred_taken), 32'h0);
        upd(32'h100, 1'b1, 32'h80, 8'h00, 1'b0);
        tick();
        idle();
        #1;
        check("sat_lo_rise", 32'(pred_taken), 32'h1);
        check("sat_branches", perf_branches, 32'd12);

        // Recovery sets GHR = {0x02[6:0],1} = 0x05
        upd(32'h2004, 1'b1, 32'h300, 8'h02, 1'b1);
        tick();
        idle();
        #1;
        check("recov_ghr", 32'(pred_ghr), 32'h05);
        check("recov_mispredicts", perf_mispredicts, 32'h1);

        // Fetch hit on 0x100 would shift to 0x0A; recovery in same cycle must win -> 0x07
        fetch_pc = 32'h100;
        fetch_valid = 1'b1;
        upd(32'h2004, 1'b1, 32'h300, 8'h03, 1'b1);
        #1;
        check("prio_snapshot", 32'(pred_ghr), 32'h05);
        tick();
        idle();
        #1;
        check("prio_ghr", 32'(pred_ghr), 32'h07);
        check("prio_mispredicts", perf_mispredicts, 32'h2);
        check("prio_branches", perf_branches, 32'd14);

        // Fetch hit (pht[0x47]=1, not taken) shifts in 0 -> 0x0E
        fetch_valid = 1'b1;
        tick();
        fetch_valid = 1'b0;
        #1;
        check("shift_ghr", 32'(pred_ghr), 32'h0E);
        // Fetch miss leaves GHR alone
        fetch_pc = 32'h4000;
        fetch_valid = 1'b1;
        tick();
        fetch_valid = 1'b0;
        #1;
        check("miss_ghr", 32'(pred_ghr), 32'h0E);
        // Stalled fetch on a hit leaves GHR alone
        fetch_pc = 32'h100;
        tick();
        check("stall_ghr", 32'(pred_ghr), 32'h0E);

        // Alias: 0x200 shares BTB set 0 with 0x100, then clear GHR via recovery
        upd(32'h100, 1'b1, 32'h80, 8'h00, 1'b0);
        tick();
        upd(32'h200, 1'b1, 32'h500, 8'h00, 1'b0);
        tick();
        upd(32'h3000, 1'b0, 32'h0, 8'h00, 1'b1);
        tick();
        idle();
        fetch_pc = 32'h100;
        #1;
        check("alias_ghr", 32'(pred_ghr), 32'h0);
        check("alias_old_taken", 32'(pred_taken), 32'h0);
        check("alias_old_target", pred_target, 32'h104);
        fetch_pc = 32'h200;
        #1;
        check("alias_new_taken", 32'(pred_taken), 32'h1);
        check("alias_new_target", pred_target, 32'h500);
        check("alias_branches", perf_branches, 32'd17);
        check("alias_mispredicts", perf_mispredicts, 32'd3);

        // Reset wins over a same-cycle taken update
        reset = 1'b1;
        upd(32'h100, 1'b1, 32'h80, 8'h00, 1'b1);
        tick();
        reset = 1'b0;
        idle();
        fetch_pc = 32'h100;
        #1;
        check("rstupd_taken_100", 32'(pred_taken), 32'h0);
        check("rstupd_target_100", pred_target, 32'h104);
        fetch_pc = 32'h200;
        #1;
        check("rstupd_target_200", pred_target, 32'h204);
        check("rstupd_ghr", 32'(pred_ghr), 32'h0);
        check("rstupd_branches", perf_branches, 32'h0);
        check("rstupd_mispredicts", perf_mispredicts, 32'h0);
        // Counter back at weakly not-taken: one taken update flips prediction
        upd(32'h200, 1'b1, 32'h500, 8'h00, 1'b0);
        tick();
        idle();
        #1;
        check("rstupd_retrain_taken", 32'(pred_taken), 32'h1);
        check("rstupd_retrain_target", pred_target, 32'h500);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
